// File: rtl/bus_cmd_pkg.sv
// Shared constants for the host byte-stream command protocol.
// The host tools mirror these opcode and response values.
package bus_cmd_pkg;

  // Command opcodes (first byte of a command)
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  // Response status codes (first byte of every response)
  localparam logic [7:0] RSP_RD      = 8'h81;
  localparam logic [7:0] RSP_WR      = 8'h82;
  localparam logic [7:0] RSP_TIMEOUT = 8'hE0;
  localparam logic [7:0] RSP_BADOP   = 8'hEF;

  // True for the opcodes that start a Wishbone cycle
  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/bus_cmd_resp_out.sv
// Two-byte response sequencer. Owns out_valid/out_data: a load presents
// byte0, and optionally byte1 on the cycle after byte0 handshakes.
// Nothing changes while out_valid && !out_ready.
module bus_cmd_resp_out (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic       has_second,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       done
);

  logic       pending;
  logic [7:0] second_q;

  // The final byte is leaving this cycle
  assign done = out_valid && out_ready && !pending;

  // Present byte0 on load, step to byte1 on handshake, drop valid after the last byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      pending   <= 1'b0;
      second_q  <= 8'h00;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= byte0;
      second_q  <= byte1;
      pending   <= has_second;
    end else if (out_valid && out_ready) begin
      if (pending) begin
        out_data <= second_q;
        pending  <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_cmd_master.sv
// Host byte stream to single 8-bit Wishbone read/write cycles, with a
// status/data byte stream back to the host. One transaction at a time.
//
// Handshakes: a byte moves on in_* when in_valid && in_ready, and on out_*
// when out_valid && out_ready, both sampled on the rising clock edge. The
// sender holds valid and data stable until the transfer happens.
module bus_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  output logic [2:0]  dbg_state
);
  import bus_cmd_pkg::*;

  typedef enum logic [2:0] {
    S_CMD    = 3'd0,
    S_ADR_HI = 3'd1,
    S_ADR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_BUS    = 3'd4,
    S_RESP0  = 3'd5,
    S_RESP1  = 3'd6
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  op_q;
  logic [15:0] cnt_q;
  logic        in_hs, bus_start, bus_end, timeout_hit;
  logic        rsp_load, rsp_two, rsp_done;
  logic [7:0]  rsp_b0, rsp_b1;

  assign dbg_state   = state;
  assign in_ready    = !rst && (state == S_CMD || state == S_ADR_HI ||
                                state == S_ADR_LO || state == S_DATA);
  assign in_hs       = in_valid && in_ready;
  assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CMD;
    else     state <= state_nxt;
  end

  // Next state, bus start/stop strobes and response selection
  always_comb begin
    state_nxt = state;
    bus_start = 1'b0;
    bus_end   = 1'b0;
    rsp_load  = 1'b0;
    rsp_b0    = 8'h00;
    rsp_b1    = 8'h00;
    rsp_two   = 1'b0;
    case (state)
      S_CMD: if (in_hs) begin
        if (is_known_op(in_data)) begin
          state_nxt = S_ADR_HI;
        end else begin
          state_nxt = S_RESP0;
          rsp_load  = 1'b1;
          rsp_b0    = RSP_BADOP;
        end
      end
      S_ADR_HI: if (in_hs) state_nxt = S_ADR_LO;
      S_ADR_LO: if (in_hs) begin
        if (op_q == OP_WRITE) begin
          state_nxt = S_DATA;
        end else begin
          state_nxt = S_BUS;
          bus_start = 1'b1;
        end
      end
      S_DATA: if (in_hs) begin
        state_nxt = S_BUS;
        bus_start = 1'b1;
      end
      S_BUS: begin
        // Ack takes priority over a timeout landing on the same cycle
        if (wb_ack_i) begin
          state_nxt = S_RESP0;
          bus_end   = 1'b1;
          rsp_load  = 1'b1;
          if (op_q == OP_WRITE) begin
            rsp_b0 = RSP_WR;
          end else begin
            rsp_b0  = RSP_RD;
            rsp_b1  = wb_dat_i;
            rsp_two = 1'b1;
          end
        end else if (timeout_hit) begin
          state_nxt = S_RESP0;
          bus_end   = 1'b1;
          rsp_load  = 1'b1;
          rsp_b0    = RSP_TIMEOUT;
        end
      end
      S_RESP0: begin
        if (rsp_done)                    state_nxt = S_CMD;
        else if (out_valid && out_ready) state_nxt = S_RESP1;
      end
      S_RESP1: if (rsp_done) state_nxt = S_CMD;
      default: state_nxt = S_CMD;
    endcase
  end

  // Command capture; address and write data hold steady through the bus cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 8'h00;
      wb_adr_o <= 16'h0000;
      wb_dat_o <= 8'h00;
    end else if (in_hs) begin
      case (state)
        S_CMD:    op_q           <= in_data;
        S_ADR_HI: wb_adr_o[15:8] <= in_data;
        S_ADR_LO: wb_adr_o[7:0]  <= in_data;
        S_DATA:   wb_dat_o       <= in_data;
        default:  ;
      endcase
    end
  end

  // Wishbone control strobes and the ack-wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
      cnt_q    <= 16'h0000;
    end else if (bus_start) begin
      wb_stb_o <= 1'b1;
      wb_cyc_o <= 1'b1;
      wb_we_o  <= (op_q == OP_WRITE);
      cnt_q    <= 16'h0000;
    end else if (bus_end) begin
      wb_stb_o <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_we_o  <= 1'b0;
    end else if (state == S_BUS) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  bus_cmd_resp_out u_resp (
    .clk        (clk),
    .rst        (rst),
    .load       (rsp_load),
    .byte0      (rsp_b0),
    .byte1      (rsp_b1),
    .has_second (rsp_two),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .done       (rsp_done)
  );

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master with TIMEOUT_CYCLES = 8.
module tb_bus_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        wb_stb_o, wb_cyc_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  bus_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_stb_o  (wb_stb_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .dbg_state (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("in_ready_wait", 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 16'(out_valid), 16'h1);
    check(tag, 16'(out_data), 16'(exp));
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    wb_dat_i = 8'h00; wb_ack_i = 1'b0;
    #1;
    check("rst_in_ready", 16'(in_ready), 16'h0);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_data", 16'(out_data), 16'h0);
    check("rst_stb_cyc_we", 16'({wb_stb_o, wb_cyc_o, wb_we_o}), 16'h0);
    check("rst_adr", wb_adr_o, 16'h0000);
    check("rst_dat_o", 16'(wb_dat_o), 16'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("idle_in_ready", 16'(in_ready), 16'h1);
    check("idle_state", 16'(dbg_state), 16'h0);

    // write 02 01 05 A5, ack after 2 clk
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h05); send_byte(8'hA5);
    check("wr_stb_cyc_we", 16'({wb_stb_o, wb_cyc_o, wb_we_o}), 16'h7);
    check("wr_adr", wb_adr_o, 16'h0105);
    check("wr_dat_o", 16'(wb_dat_o), 16'hA5);
    check("wr_in_ready_bus", 16'(in_ready), 16'h0);
    tick(); tick();
    check("wr_stb_hold", 16'({wb_stb_o, wb_cyc_o, wb_we_o}), 16'h7);
    wb_ack_i = 1'b1; wb_dat_i = 8'hFF;
    tick();
    wb_ack_i = 1'b0;
    check("wr_stb_drop", 16'({wb_stb_o, wb_cyc_o, wb_we_o}), 16'h0);
    recv_byte("wr_rsp", 8'h82);
    check("wr_done_valid", 16'(out_valid), 16'h0);
    check("wr_done_in_ready", 16'(in_ready), 16'h1);

    // read 01 00 03, combinational ack with 5C
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    check("rd_stb_cyc_we", 16'({wb_stb_o, wb_cyc_o, wb_we_o}), 16'h6);
    check("rd_adr", wb_adr_o, 16'h0003);
    wb_ack_i = 1'b1; wb_dat_i = 8'h5C;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 8'h33;
    check("rd_stb_drop", 16'(wb_stb_o), 16'h0);
    check("rd_latency_valid", 16'(out_valid), 16'h1);
    recv_byte("rd_rsp0", 8'h81);
    recv_byte("rd_rsp1", 8'h5C);
    check("rd_done_valid", 16'(out_valid), 16'h0);

    // timeout: no ack, stb high exactly 8 clk
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    n = 0;
    while (wb_stb_o && n < 20) begin
      n++;
      tick();
    end
    check("to_stb_cycles", 16'(n), 16'd8);
    check("to_cyc_drop", 16'(wb_cyc_o), 16'h0);
    recv_byte("to_rsp", 8'hE0);

    // bad opcode, then a normal read
    send_byte(8'h7F);
    check("bad_valid", 16'(out_valid), 16'h1);
    check("bad_no_bus", 16'({wb_stb_o, wb_cyc_o}), 16'h0);
    check("bad_in_ready", 16'(in_ready), 16'h0);
    recv_byte("bad_rsp", 8'hEF);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
    check("bad_next_adr", wb_adr_o, 16'h0200);
    wb_ack_i = 1'b1; wb_dat_i = 8'hA7;
    tick();
    wb_ack_i = 1'b0;
    recv_byte("bad_next_rsp0", 8'h81);
    recv_byte("bad_next_rsp1", 8'hA7);

    // back-pressure: out_ready low for 10 clk while host keeps offering bytes
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h09);
    wb_ack_i = 1'b1; wb_dat_i = 8'h3D;
    tick();
    wb_ack_i = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 10; i++) begin
      check("bp_data", 16'(out_data), 16'h81);
      check("bp_valid_in_ready", 16'({out_valid, in_ready}), 16'h2);
      tick();
    end
    in_valid = 1'b0;
    recv_byte("bp_rsp0", 8'h81);
    recv_byte("bp_rsp1", 8'h3D);

    // ack on the timeout cycle wins
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h0A);
    for (int i = 0; i < 7; i++) tick();
    check("edge_stb_still", 16'(wb_stb_o), 16'h1);
    wb_ack_i = 1'b1; wb_dat_i = 8'hC3;
    tick();
    wb_ack_i = 1'b0;
    recv_byte("edge_rsp0", 8'h81);
    recv_byte("edge_rsp1", 8'hC3);

    // reset mid-BUS
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h44); send_byte(8'h99);
    check("rb_stb_before", 16'(wb_stb_o), 16'h1);
    rst = 1'b1;
    #1;
    check("rb_stb_cyc", 16'({wb_stb_o, wb_cyc_o}), 16'h0);
    check("rb_out_valid", 16'(out_valid), 16'h0);
    check("rb_in_ready", 16'(in_ready), 16'h0);
    check("rb_adr", wb_adr_o, 16'h0000);
    tick();
    rst = 1'b0;
    #1;
    check("rb_release_state", 16'(dbg_state), 16'h0);

    // reset mid-ADR_LO
    send_byte(8'h01); send_byte(8'h00);
    check("ra_state", 16'(dbg_state), 16'h2);
    rst = 1'b1;
    #1;
    check("ra_state_rst", 16'(dbg_state), 16'h0);
    check("ra_out_stb", 16'({out_valid, wb_stb_o}), 16'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    check("ra_no_response", 16'(out_valid), 16'h0);
    out_ready = 1'b0;
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
    check("ra_adr", wb_adr_o, 16'h0100);
    check("ra_dat_we", 16'({wb_we_o, wb_dat_o}), 16'h111);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    recv_byte("ra_rsp", 8'h82);
    check("ra_end_valid", 16'(out_valid), 16'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
